// File: rtl/param_mem_arbiter.sv
// param_mem_arbiter: shares one single-port parameter RAM (1-cycle read latency)
// between the DSP coefficient fetch (read-only, high priority) and the SPI
// control path (read/write, low priority with a starvation guard).
// Optional feature macro: PARAM_ARB_WRITE_BUFFER_EN adds a one-entry posted
// write buffer with read forwarding for the DSP side.
module param_mem_arbiter #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dsp_req,
    input  logic [ADDR_WIDTH-1:0] dsp_addr,
    output logic                  dsp_ready,
    output logic                  dsp_rvalid,
    output logic [WORD_WIDTH-1:0] dsp_rdata,
    input  logic                  spi_req,
    input  logic                  spi_we,
    input  logic [ADDR_WIDTH-1:0] spi_addr,
    input  logic [WORD_WIDTH-1:0] spi_wdata,
    output logic                  spi_ready,
    output logic                  spi_rvalid,
    output logic [WORD_WIDTH-1:0] spi_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] WaitLimit = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       dsp_rvalid_q, spi_rvalid_q;
    logic       wait_full;
    logic       dsp_grant;
    logic       spi_grant;
    logic       spi_rd_grant;
    logic       wait_inc;

`ifdef PARAM_ARB_WRITE_BUFFER_EN
    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [WORD_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  fwd_q, fwd_d;
    logic [WORD_WIDTH-1:0] fwd_data_q;
    logic                  drain;
    logic                  spi_wr_accept;
`endif

    // Arbitration and RAM drive: decide who owns the RAM port this cycle; everything is held at 0 in reset
    always_comb begin
        wait_full    = (wait_cnt_q == WaitLimit);
        dsp_grant    = 1'b0;
        spi_grant    = 1'b0;
        spi_rd_grant = 1'b0;
        wait_inc     = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
`ifdef PARAM_ARB_WRITE_BUFFER_EN
        drain         = 1'b0;
        spi_wr_accept = 1'b0;
        if (reset_n) begin
            drain         = wb_valid_q && (!dsp_req || wait_full);
            spi_rd_grant  = spi_req && !spi_we && !wb_valid_q && (!dsp_req || wait_full);
            spi_wr_accept = spi_req && spi_we && (!wb_valid_q || drain);
            spi_grant     = spi_rd_grant || spi_wr_accept;
            dsp_grant     = dsp_req && !drain && !spi_rd_grant;
            mem_we        = drain;
            mem_addr      = drain ? wb_addr_q : (spi_rd_grant ? spi_addr : dsp_addr);
            mem_wdata     = wb_data_q;
            wait_inc      = (spi_req && !spi_grant) || (wb_valid_q && !drain);
        end
`else
        if (reset_n) begin
            spi_grant    = spi_req && (wait_full || !dsp_req);
            spi_rd_grant = spi_grant && !spi_we;
            dsp_grant    = dsp_req && !spi_grant;
            mem_we       = spi_grant && spi_we;
            mem_addr     = spi_grant ? spi_addr : dsp_addr;
            mem_wdata    = spi_wdata;
            wait_inc     = spi_req && !spi_grant;
        end
`endif
    end

    // Starvation counter: counts refused cycles, saturates at the limit, clears otherwise
    always_comb begin
        wait_cnt_d = '0;
        if (wait_inc) begin
            wait_cnt_d = wait_full ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    // Core state: wait counter and one-cycle read-return flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q   <= '0;
            dsp_rvalid_q <= 1'b0;
            spi_rvalid_q <= 1'b0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            dsp_rvalid_q <= dsp_grant;
            spi_rvalid_q <= spi_rd_grant;
        end
    end

`ifdef PARAM_ARB_WRITE_BUFFER_EN
    // Buffer next state: drain empties it, an accepted write refills it (drain and refill may share a cycle)
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (drain) begin
            wb_valid_d = 1'b0;
        end
        if (spi_wr_accept) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = spi_addr;
            wb_data_d  = spi_wdata;
        end
        fwd_d = dsp_grant && wb_valid_q && (dsp_addr == wb_addr_q);
    end

    // Buffer registers plus the forward flag/data captured with the DSP grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= wb_data_q;
        end
    end

    assign dsp_rdata = reset_n ? (fwd_q ? fwd_data_q : mem_rdata) : '0;
`else
    assign dsp_rdata = reset_n ? mem_rdata : '0;
`endif

    assign spi_rdata  = reset_n ? mem_rdata : '0;
    assign dsp_ready  = dsp_grant;
    assign spi_ready  = spi_grant;
    assign dsp_rvalid = dsp_rvalid_q;
    assign spi_rvalid = spi_rvalid_q;

endmodule

// File: doc/param_mem_arbiter.md
# param_mem_arbiter

Shares one single-port parameter RAM (1-cycle read latency) between two requesters: the DSP coefficient fetch (read-only, high priority) and the SPI control path behind the packet/memif layer (read/write, low priority with a starvation guard). At most one RAM access is issued per cycle. Read data is returned to the granted requester one cycle after grant. An optional one-entry posted write buffer decouples SPI writes from DSP traffic.

## Interface
Parameters:
- WORD_WIDTH, 8, data word width
- ADDR_WIDTH, 2, RAM address width
- MAX_WAIT, 4, consecutive cycles an SPI request may be refused before it is forced through (1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- dsp_req  in  1  DSP read request
- dsp_addr  in  ADDR_WIDTH  DSP read address
- dsp_ready  out  1  DSP request granted this cycle
- dsp_rvalid  out  1  dsp_rdata valid
- dsp_rdata  out  WORD_WIDTH  DSP read data
- spi_req  in  1  SPI request
- spi_we  in  1  1 = write, 0 = read
- spi_addr  in  ADDR_WIDTH  SPI address
- spi_wdata  in  WORD_WIDTH  SPI write data
- spi_ready  out  1  SPI request accepted this cycle
- spi_rvalid  out  1  spi_rdata valid
- spi_rdata  out  WORD_WIDTH  SPI read data
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  WORD_WIDTH  RAM write data
- mem_rdata  in  WORD_WIDTH  RAM read data, valid the cycle after mem_addr is presented

## Operation
- Request/accept: a request transfers on a cycle where req and ready are both high. The requester holds addr/we/wdata stable while req is high and ready is low.
- dsp_ready and spi_ready are combinational from the requests and the registered state. Both are forced to 0 while reset_n is low.
- Arbitration (buffer compiled out):
  - Grant SPI if spi_req and (wait_cnt == MAX_WAIT or !dsp_req).
  - Otherwise grant DSP if dsp_req.
  - Never both in one cycle.
- wait_cnt (4 bits, reset 0):
  - Increments, saturating at MAX_WAIT, when spi_req is high and SPI is not accepted.
  - Clears when SPI is accepted or spi_req is low.
- RAM drive:
  - mem_addr is the granted address. It is dsp_addr when idle.
  - mem_we = 1 only for a granted SPI write, or a buffer drain.
  - mem_wdata is the write data.
- Read return:
  - dsp_rvalid and spi_rvalid are registered: high exactly one cycle after a read grant, otherwise 0.
  - *_rdata = mem_rdata, or the forwarded value (see Configuration).
  - SPI write grants produce no rvalid.
- Reset values: dsp_rvalid = 0, spi_rvalid = 0, wait_cnt = 0, buffer empty, mem_we = 0, dsp_ready = spi_ready = 0.
- Reset asserted mid-transfer: any outstanding rvalid is dropped and any buffered write is lost. The requester re-issues after reset.

## Timing
- Read latency: grant in cycle N, *_rvalid and *_rdata in cycle N+1. Back-to-back grants give one result per cycle.
- Write: mem_we is asserted in the accept cycle, so the RAM is updated at the end of cycle N. A read granted in N+1 returns the new value.
- Worst-case SPI wait under continuous dsp_req: MAX_WAIT refused cycles. The next cycle is accepted.
- Simultaneous requests with wait_cnt < MAX_WAIT: DSP wins.

## Configuration
- PARAM_ARB_WRITE_BUFFER_EN defined: one-entry buffer (wb_valid, wb_addr, wb_data).
  - SPI write is accepted when !wb_valid or the buffer drains this cycle. Accept loads the buffer and uses no RAM cycle.
  - The buffer drains (mem_we = 1) on any cycle the DSP is not granted. Drain takes precedence over SPI reads.
  - Starvation: when wait_cnt == MAX_WAIT and wb_valid, the drain is forced over the DSP. wait_cnt counts while wb_valid is set or an SPI read is refused.
  - An SPI read is not accepted while wb_valid is set.
  - A DSP read granted while wb_valid is set and dsp_addr == wb_addr returns wb_data (forward flag registered with the grant).
  - A write accepted in the same cycle as a DSP read to the same address is ordered after the read, so the read returns the old data.
- PARAM_ARB_WRITE_BUFFER_EN undefined: no buffer. Writes go straight to the RAM on grant, as in Operation.

## Test plan
- Reset, then DSP reads addr 2 with mem[2]=0x5A -> dsp_ready in cycle 0; dsp_rvalid=1 and dsp_rdata=0x5A in cycle 1; all outputs 0 while reset_n is low.
- dsp_req held high continuously, SPI write 0x33 to addr 1 with MAX_WAIT=4 -> spi_ready low for 4 cycles, high on the 5th with mem_we=1; DSP refused that cycle; mem[1]=0x33 afterwards.
- Simultaneous DSP read addr 0 and SPI read addr 3 with both requests held -> DSP granted first; SPI granted within MAX_WAIT+1 cycles; each rvalid pulses exactly once.
- SPI write 0xA5 to addr 1, then SPI read addr 1 -> spi_rdata=0xA5.
- Buffer on, DSP continuous, SPI write 0x77 to addr 2 -> spi_ready in the same cycle; a DSP read of addr 2 returns 0x77 via forwarding before the drain; drain forced after 4 cycles; RAM then holds 0x77.
- Buffer on, reset_n pulsed low while wb_valid=1 -> buffer cleared, no mem_we after reset, mem[addr] unchanged.
